// File: rtl/shift_register_ctrl.sv
// Parameterised shift register with parallel load, serial in/out and preset/clear/set controls.
// Everything is synchronous to the rising edge of clock, including the active-low reset.
module shift_register_ctrl #(
  parameter int unsigned SHIFT_WIDTH     = 8,
  parameter int unsigned SHIFT_DIRECTION = 0,
  parameter int unsigned LOAD_AVALUE     = 2,
  parameter int unsigned LOAD_SVALUE     = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   pset,
  input  logic                   sclr,
  input  logic                   sset,
  input  logic                   enable,
  input  logic                   load,
  input  logic                   shiftin,
  input  logic [SHIFT_WIDTH-1:0] data,
  output logic                   shiftout,
  output logic [SHIFT_WIDTH-1:0] q
);

  // Preset constants are truncated or zero-extended to the register width.
  localparam logic [SHIFT_WIDTH-1:0] AVALUE = SHIFT_WIDTH'(LOAD_AVALUE);
  localparam logic [SHIFT_WIDTH-1:0] SVALUE = SHIFT_WIDTH'(LOAD_SVALUE);

  logic [SHIFT_WIDTH-1:0] shifted;

  // shiftout is the bit the next shift will expel, taken straight from q.
  generate
    if (SHIFT_DIRECTION == 0) begin : g_left
      assign shifted  = {q[SHIFT_WIDTH-2:0], shiftin};
      assign shiftout = q[SHIFT_WIDTH-1];
    end else begin : g_right
      assign shifted  = {shiftin, q[SHIFT_WIDTH-1:1]};
      assign shiftout = q[0];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      q <= '0;
    end else if (pset) begin
      q <= AVALUE;
    end else if (sclr) begin
      q <= '0;
    end else if (sset) begin
      q <= SVALUE;
    end else if (enable && load) begin
      q <= data;
    end else if (enable) begin
      q <= shifted;
    end
  end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl: directed vector table, hand sequences and randomized
// traffic against an arithmetic reference model, for both left- and right-shifting builds.
module tb_shift_register_ctrl;

  logic       clock = 1'b0;
  logic       rst_n, pset, sclr, sset, enable, load, shiftin;
  logic [7:0] data;
  logic       so_l, so_r;
  logic [7:0] q_l, q_r;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl_l, mdl_r;

  always #5 clock = ~clock;

  shift_register_ctrl #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION(0), .LOAD_AVALUE(2), .LOAD_SVALUE(4)) dut_l (
    .clock(clock), .rst_n(rst_n), .pset(pset), .sclr(sclr), .sset(sset), .enable(enable),
    .load(load), .shiftin(shiftin), .data(data), .shiftout(so_l), .q(q_l)
  );

  shift_register_ctrl #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION(1), .LOAD_AVALUE(2), .LOAD_SVALUE(4)) dut_r (
    .clock(clock), .rst_n(rst_n), .pset(pset), .sclr(sclr), .sset(sset), .enable(enable),
    .load(load), .shiftin(shiftin), .data(data), .shiftout(so_r), .q(q_r)
  );

  typedef struct {
    logic       rst_n, pset, sclr, sset, enable, load, shiftin;
    logic [7:0] data;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  vec_t vecs[15];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next state from the priority list, shifting by plain arithmetic.
  function automatic logic [7:0] ref_next(input logic [7:0] cur, input bit right);
    int v;
    if (!rst_n) return 8'h00;
    if (pset) return 8'h02;
    if (sclr) return 8'h00;
    if (sset) return 8'h04;
    if (enable && load) return data;
    if (enable) begin
      if (right) v = int'(cur) / 2 + int'(shiftin) * 128;
      else v = (int'(cur) * 2 + int'(shiftin)) % 256;
      return 8'(v);
    end
    return cur;
  endfunction

  task automatic step();
    mdl_l = ref_next(mdl_l, 1'b0);
    mdl_r = ref_next(mdl_r, 1'b1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    check8({tag, "_q_left"}, q_l, mdl_l);
    check1({tag, "_so_left"}, so_l, (int'(mdl_l) >= 128));
    check8({tag, "_q_right"}, q_r, mdl_r);
    check1({tag, "_so_right"}, so_r, (int'(mdl_r) % 2) == 1);
  endtask

  task automatic set_in(input logic r, input logic p, input logic c, input logic s,
                        input logic e, input logic l, input logic si, input logic [7:0] d);
    rst_n = r; pset = p; sclr = c; sset = s; enable = e; load = l; shiftin = si; data = d;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h02, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hEE, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h99, 8'h04, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h4A, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h95, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h95, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h56, 8'h01, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 8'h02, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 1'b0};

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    mdl_l = 8'h00;
    mdl_r = 8'h00;
    #1;

    // Reset held for 10 edges with random other inputs.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
      step();
      check8("reset_q_left", q_l, 8'h00);
      check1("reset_so_left", so_l, 1'b0);
      check8("reset_q_right", q_r, 8'h00);
      check1("reset_so_right", so_r, 1'b0);
    end

    // Directed table for the left-shifting build; right build follows the model.
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].rst_n, vecs[i].pset, vecs[i].sclr, vecs[i].sset,
             vecs[i].enable, vecs[i].load, vecs[i].shiftin, vecs[i].data);
      step();
      check8($sformatf("vec%0d_q", i), q_l, vecs[i].exp_q);
      check1($sformatf("vec%0d_so", i), so_l, vecs[i].exp_so);
      check8($sformatf("vec%0d_q_right", i), q_r, mdl_r);
    end

    // Right shift: A5 with shiftin=1 becomes D2.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
    step();
    check8("dir1_load_q", q_r, 8'hA5);
    check1("dir1_load_so", so_r, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step();
    check8("dir1_shift_q", q_r, 8'hD2);
    check1("dir1_shift_so", so_r, 1'b0);
    check8("dir1_shift_q_left", q_l, 8'h4B);

    // Reset mid-shift, then resume shifting from zero.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step();
    check8("midrst_q_right", q_r, 8'h00);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step();
    check8("resume_q_right", q_r, 8'h80);
    check1("resume_so_right", so_r, 1'b0);
    check8("resume_q_left", q_l, 8'h01);

    // Randomized traffic, controls weighted so loads and shifts dominate.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 14) == 0),
             1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 14) == 0),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
